// File: rtl/sync_corr_window_acc.sv
// Sliding-window accumulator for the sync correlator: running sum of the last WINDOW products,
// scaled by SHIFT and narrowed to OUT_WIDTH. Define SYNC_CORR_ACC_SAT_EN to saturate instead of wrap.
module sync_corr_window_acc #(
  parameter int PROD_WIDTH = 54,
  parameter int WINDOW     = 16,
  parameter int ACC_WIDTH  = 58,
  parameter int SHIFT      = 26,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         sync_clear,
  input  logic signed [PROD_WIDTH-1:0] prod_din,
  input  logic                         prod_valid,
  output logic                         prod_ready,
  output logic signed [OUT_WIDTH-1:0]  sum_dout,
  output logic                         sum_valid,
  input  logic                         sum_ready,
  output logic                         win_full
);

  localparam int PW = $clog2(WINDOW);

  typedef enum logic {FILL, RUN} state_t;

  state_t                         state;
  logic        [PW:0]             fill_cnt;
  logic        [PW-1:0]           wr_ptr;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [PROD_WIDTH-1:0]   dline [WINDOW];

  logic                           accept;
  logic                           last_fill;
  logic                           produce;
  logic signed [ACC_WIDTH-1:0]    evict;
  logic signed [ACC_WIDTH-1:0]    acc_nxt;
  logic signed [OUT_WIDTH-1:0]    out_nxt;

  assign prod_ready = !sync_clear && (!sum_valid || sum_ready);
  assign accept     = prod_valid && prod_ready;
  assign last_fill  = (state == FILL) && (fill_cnt == (PW+1)'(WINDOW-1));
  assign produce    = (state == RUN) || last_fill;

  // Nothing has been written at wr_ptr yet while filling, so there is nothing to evict.
  assign evict   = (state == RUN) ?
                   {{(ACC_WIDTH-PROD_WIDTH){dline[wr_ptr][PROD_WIDTH-1]}}, dline[wr_ptr]} : '0;
  assign acc_nxt = acc + {{(ACC_WIDTH-PROD_WIDTH){prod_din[PROD_WIDTH-1]}}, prod_din} - evict;

`ifdef SYNC_CORR_ACC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] OMAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OMIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  logic signed [ACC_WIDTH-1:0] shifted;

  always_comb begin
    shifted = acc_nxt >>> SHIFT;
    out_nxt = shifted[OUT_WIDTH-1:0];
    if (shifted > OMAX)      out_nxt = OMAX[OUT_WIDTH-1:0];
    else if (shifted < OMIN) out_nxt = OMIN[OUT_WIDTH-1:0];
  end
`else
  always_comb begin
    out_nxt = OUT_WIDTH'(acc_nxt >>> SHIFT);
  end
`endif

  // Delay line is not reset: entries are only read once overwritten in the current window.
  always_ff @(posedge ap_clk) begin
    if (accept) dline[wr_ptr] <= prod_din;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state     <= FILL;
      fill_cnt  <= '0;
      wr_ptr    <= '0;
      acc       <= '0;
      win_full  <= 1'b0;
      sum_valid <= 1'b0;
      sum_dout  <= '0;
    end else if (sync_clear) begin
      state     <= FILL;
      fill_cnt  <= '0;
      wr_ptr    <= '0;
      acc       <= '0;
      win_full  <= 1'b0;
      sum_valid <= 1'b0;
      sum_dout  <= '0;
    end else begin
      if (accept) begin
        acc    <= acc_nxt;
        wr_ptr <= wr_ptr + PW'(1);
        if (state == FILL) fill_cnt <= fill_cnt + (PW+1)'(1);
        if (last_fill) begin
          state    <= RUN;
          win_full <= 1'b1;
        end
      end
      // A new result can replace one being handed off in the same cycle.
      if (accept && produce) begin
        sum_valid <= 1'b1;
        sum_dout  <= out_nxt;
      end else if (sum_ready) begin
        sum_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_corr_window_acc.sv
// Scoreboard bench for sync_corr_window_acc (SHIFT=0): fill, slide, backpressure, clear, saturation, async reset.
module tb_sync_corr_window_acc;

  localparam int W = 16;
  localparam longint OMAX = (longint'(1) <<< 31) - 1;
  localparam longint OMIN = -(longint'(1) <<< 31);

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        sync_clear = 1'b0;
  logic [53:0] prod_din = '0;
  logic        prod_valid = 1'b0;
  logic        prod_ready;
  logic [31:0] sum_dout;
  logic        sum_valid;
  logic        sum_ready = 1'b0;
  logic        win_full;

  int n_cmp = 0;
  int n_bad = 0;

  longint      win[$];
  logic [31:0] sbq[$];
  longint      m_acc = 0;
  bit          m_full = 1'b0;
  longint      cur_pd = 0;

  sync_corr_window_acc #(.PROD_WIDTH(54), .WINDOW(W), .ACC_WIDTH(58), .SHIFT(0), .OUT_WIDTH(32)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .sync_clear(sync_clear),
    .prod_din(prod_din), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .sum_dout(sum_dout), .sum_valid(sum_valid), .sum_ready(sum_ready), .win_full(win_full)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [31:0] narrow(input longint v);
`ifdef SYNC_CORR_ACC_SAT_EN
    if (v > OMAX) return 32'h7fffffff;
    if (v < OMIN) return 32'h80000000;
`endif
    return v[31:0];
  endfunction

  function automatic bit exp_ready();
    return !sync_clear && (sbq.size() == 0 || sum_ready);
  endfunction

  task automatic model_reset();
    win.delete();
    sbq.delete();
    m_acc  = 0;
    m_full = 1'b0;
  endtask

  task automatic drive(input bit pv, input longint pd, input bit sr, input bit clr);
    prod_valid = pv;
    cur_pd     = pd;
    prod_din   = pd[53:0];
    sum_ready  = sr;
    sync_clear = clr;
    #1;
  endtask

  // Advance one clock and update the reference model with what the edge should do.
  task automatic tick();
    bit acc;
    acc = prod_valid && exp_ready();
    @(posedge ap_clk);
    if (sync_clear) model_reset();
    else begin
      if (sbq.size() != 0 && sum_ready) void'(sbq.pop_front());
      if (acc) begin
        win.push_back(cur_pd);
        m_acc += cur_pd;
        if (win.size() > W) m_acc -= win.pop_front();
        if (win.size() == W) begin
          m_full = 1'b1;
          sbq.push_back(narrow(m_acc));
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", sum_valid); end
    n_cmp++; if (win_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b want=0", win_full); end
    n_cmp++; if (sum_dout !== 32'd0) begin n_bad++; $display("FAIL reset_dout got=%h want=0", sum_dout); end
    n_cmp++; if (prod_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", prod_ready); end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fill(input string tag);
    for (int i = 1; i <= W; i++) begin
      drive(1'b1, 1, 1'b1, 1'b0);
      tick();
      n_cmp++; if (sum_valid !== (sbq.size() != 0)) begin n_bad++; $display("FAIL %s_valid s%0d got=%b want=%b", tag, i, sum_valid, sbq.size() != 0); end
      n_cmp++; if (win_full !== m_full) begin n_bad++; $display("FAIL %s_full s%0d got=%b want=%b", tag, i, win_full, m_full); end
      if (i == W) begin
        n_cmp++; if (sum_dout !== 32'd16) begin n_bad++; $display("FAIL %s_sum got=%h want=10", tag, sum_dout); end
        n_cmp++; if (win_full !== 1'b1) begin n_bad++; $display("FAIL %s_primed got=%b want=1", tag, win_full); end
      end
    end
  endtask

  task automatic test_slide();
    for (int i = 1; i <= W; i++) begin
      drive(1'b1, -1, 1'b1, 1'b0);
      tick();
      n_cmp++; if (sum_valid !== 1'b1) begin n_bad++; $display("FAIL slide_valid s%0d got=%b want=1", i, sum_valid); end
      n_cmp++; if (sum_dout !== 32'(16 - 2*i)) begin n_bad++; $display("FAIL slide_sum s%0d got=%h want=%h", i, sum_dout, 32'(16 - 2*i)); end
      if (sbq.size() != 0) begin
        n_cmp++; if (sum_dout !== sbq[0]) begin n_bad++; $display("FAIL slide_model s%0d got=%h want=%h", i, sum_dout, sbq[0]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    held = sum_dout;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, longint'(i*3 - 7), i >= 5, 1'b0);
      n_cmp++; if (prod_ready !== exp_ready()) begin n_bad++; $display("FAIL bp_ready c%0d got=%b want=%b", i, prod_ready, exp_ready()); end
      tick();
      n_cmp++; if (sum_valid !== (sbq.size() != 0)) begin n_bad++; $display("FAIL bp_valid c%0d got=%b want=%b", i, sum_valid, sbq.size() != 0); end
      if (sbq.size() != 0) begin
        n_cmp++; if (sum_dout !== sbq[0]) begin n_bad++; $display("FAIL bp_sum c%0d got=%h want=%h", i, sum_dout, sbq[0]); end
      end
      if (i < 5) begin
        n_cmp++; if (sum_dout !== held) begin n_bad++; $display("FAIL bp_hold c%0d got=%h want=%h", i, sum_dout, held); end
      end
    end
    drive(1'b0, 0, 1'b1, 1'b0);
    tick();
    n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got=%b want=0", sum_valid); end
  endtask

  task automatic test_clear();
    longint v;
    drive(1'b1, 50, 1'b1, 1'b0);
    tick();
    drive(1'b1, 100, 1'b0, 1'b1);
    n_cmp++; if (prod_ready !== 1'b0) begin n_bad++; $display("FAIL clr_ready got=%b want=0", prod_ready); end
    tick();
    n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL clr_valid got=%b want=0", sum_valid); end
    n_cmp++; if (win_full !== 1'b0) begin n_bad++; $display("FAIL clr_full got=%b want=0", win_full); end
    for (int i = 1; i <= W; i++) begin
      v = longint'($urandom_range(2000)) - 1000;
      drive(1'b1, v, 1'b1, 1'b0);
      tick();
      n_cmp++; if (sum_valid !== (i == W)) begin n_bad++; $display("FAIL clr_refill_valid s%0d got=%b want=%b", i, sum_valid, i == W); end
      if (sbq.size() != 0) begin
        n_cmp++; if (sum_dout !== sbq[0]) begin n_bad++; $display("FAIL clr_refill_sum s%0d got=%h want=%h", i, sum_dout, sbq[0]); end
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] want;
`ifdef SYNC_CORR_ACC_SAT_EN
    want = 32'h7fffffff;
`else
    want = 32'h00000000;
`endif
    drive(1'b0, 0, 1'b1, 1'b1);
    tick();
    for (int i = 1; i <= W; i++) begin
      drive(1'b1, longint'(1) <<< 30, 1'b1, 1'b0);
      tick();
    end
    n_cmp++; if (sum_valid !== 1'b1) begin n_bad++; $display("FAIL sat_valid got=%b want=1", sum_valid); end
    n_cmp++; if (sum_dout !== want) begin n_bad++; $display("FAIL sat_sum got=%h want=%h", sum_dout, want); end
    n_cmp++; if (sum_dout !== sbq[0]) begin n_bad++; $display("FAIL sat_model got=%h want=%h", sum_dout, sbq[0]); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5, 1'b0, 1'b0);
    tick();
    tick();
    n_cmp++; if (sum_valid !== 1'b1) begin n_bad++; $display("FAIL arst_pre_valid got=%b want=1", sum_valid); end
    #2 ap_rst = 1'b1;
    #1;
    n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid got=%b want=0", sum_valid); end
    n_cmp++; if (win_full !== 1'b0) begin n_bad++; $display("FAIL arst_full got=%b want=0", win_full); end
    n_cmp++; if (sum_dout !== 32'd0) begin n_bad++; $display("FAIL arst_dout got=%h want=0", sum_dout); end
    n_cmp++; if (prod_ready !== 1'b1) begin n_bad++; $display("FAIL arst_ready got=%b want=1", prod_ready); end
    #1 ap_rst = 1'b0;
    model_reset();
    test_fill("refill");
  endtask

  initial begin
    test_reset();
    test_fill("fill");
    test_slide();
    test_backpressure();
    test_clear();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
